// File: rtl/mem_stack_stage_pkg.sv
// Shared definitions for the memory-access stage of the 8-bit core.
// Holds the memory operation codes, the SP reset default, and the
// decoder that turns the raw opcode and qualifiers into an effective op.
package mem_stage_pkg;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_LOAD  = 3'd1,
    OP_STORE = 3'd2,
    OP_PUSH  = 3'd3,
    OP_POP   = 3'd4
  } mem_op_e;

  localparam logic [7:0] SP_INIT_DEFAULT = 8'hFF;

  // An invalid or flushed slot, or an unused code (5..7), does nothing.
  function automatic mem_op_e decode_op(input logic valid,
                                        input logic flush,
                                        input logic [2:0] op);
    mem_op_e res;
    res = OP_NONE;
    if (valid && !flush) begin
      case (op)
        3'd1:    res = OP_LOAD;
        3'd2:    res = OP_STORE;
        3'd3:    res = OP_PUSH;
        3'd4:    res = OP_POP;
        default: res = OP_NONE;
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/mem_stack_stage_if.sv
// Bus between EX/MEM and the memory-access stage, plus the MEM/WB outputs.
// master: the upstream pipeline (drives op/operands/stall/flush, sees wb_*).
// slave : mem_stack_stage (consumes op/operands, drives wb_*, sp_out, stack_err).
interface mem_stack_stage_if #(
  parameter int AW = 8,
  parameter int DW = 8
);

  logic          valid;
  logic [2:0]    op;
  logic [AW-1:0] addr;
  logic [DW-1:0] data_in;
  logic [DW-1:0] alu_result;
  logic [1:0]    rd;
  logic          reg_we_in;
  logic          stall;
  logic          flush;

  logic          wb_valid;
  logic [DW-1:0] wb_data;
  logic [1:0]    wb_rd;
  logic          wb_reg_we;
  logic [AW-1:0] sp_out;
  logic          stack_err;

  modport master (
    output valid, op, addr, data_in, alu_result, rd, reg_we_in, stall, flush,
    input  wb_valid, wb_data, wb_rd, wb_reg_we, sp_out, stack_err
  );

  modport slave (
    input  valid, op, addr, data_in, alu_result, rd, reg_we_in, stall, flush,
    output wb_valid, wb_data, wb_rd, wb_reg_we, sp_out, stack_err
  );

endinterface

// File: rtl/mem_stack_stage_data_ram.sv
// Data RAM for the memory-access stage: DEPTH x DW bytes,
// one asynchronous read port and one synchronous write port.
// Ports: clk, we/waddr/wdata (write at rising edge), raddr/rdata (comb read).
// Contents are never reset.
module data_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int DW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_stack_stage.sv
// Memory-access stage: data RAM, stack pointer and the MEM/WB register.
// Executes one LOAD/STORE/PUSH/POP per non-stalled cycle; results reach
// wb_* one cycle after the operands are presented.
// Ports: clk, rst (synchronous, active-low), bus (mem_stack_stage_if.slave:
// valid/op/addr/data_in/alu_result/rd/reg_we_in/stall/flush in;
// wb_valid/wb_data/wb_rd/wb_reg_we/sp_out/stack_err out).
// DEPTH must equal 2**AW so SP arithmetic wraps exactly at the RAM edge.
module mem_stack_stage
  import mem_stage_pkg::*;
#(
  parameter int            DEPTH   = 256,
  parameter int            AW      = 8,
  parameter int            DW      = 8,
  parameter logic [AW-1:0] SP_INIT = AW'(SP_INIT_DEFAULT)
) (
  input logic              clk,
  input logic              rst,
  mem_stack_stage_if.slave bus
);

  mem_op_e       eff_op_p0;
  logic [AW-1:0] sp_p1;
  logic [AW-1:0] sp_inc_p0;
  logic [AW-1:0] sp_dec_p0;
  logic [AW-1:0] sp_nxt_p0;
  logic [AW-1:0] raddr_p0;
  logic [AW-1:0] waddr_p0;
  logic [DW-1:0] rdata_p0;
  logic [DW-1:0] wb_data_nxt_p0;
  logic          we_p0;
  logic          vld_p0;
  logic          reg_we_nxt_p0;
  logic          stack_fault_p0;

  logic          vld_p1;
  logic [DW-1:0] wb_data_p1;
  logic [1:0]    wb_rd_p1;
  logic          wb_reg_we_p1;
  logic          stack_err_p1;

  // Stage p0: decode, address selection, SP arithmetic, RAM access
  always_comb begin
    eff_op_p0      = decode_op(bus.valid, bus.flush, bus.op);
    vld_p0         = bus.valid && !bus.flush;
    sp_inc_p0      = sp_p1 + AW'(1);
    sp_dec_p0      = sp_p1 - AW'(1);

    // POP reads the byte above SP; everything else reads the effective address.
    raddr_p0       = (eff_op_p0 == OP_POP) ? sp_inc_p0 : bus.addr;
    // PUSH writes at SP itself (post-decrement stack).
    waddr_p0       = (eff_op_p0 == OP_PUSH) ? sp_p1 : bus.addr;
    we_p0          = rst && !bus.stall &&
                     ((eff_op_p0 == OP_STORE) || (eff_op_p0 == OP_PUSH));

    sp_nxt_p0      = sp_p1;
    stack_fault_p0 = 1'b0;
    case (eff_op_p0)
      OP_PUSH: begin
        sp_nxt_p0      = sp_dec_p0;
        stack_fault_p0 = (sp_p1 == '0);
      end
      OP_POP: begin
        sp_nxt_p0      = sp_inc_p0;
        stack_fault_p0 = (sp_p1 == '1);
      end
      default: ;
    endcase

    wb_data_nxt_p0 = ((eff_op_p0 == OP_LOAD) || (eff_op_p0 == OP_POP)) ?
                     rdata_p0 : bus.alu_result;
    reg_we_nxt_p0  = bus.reg_we_in && vld_p0 &&
                     !((eff_op_p0 == OP_STORE) || (eff_op_p0 == OP_PUSH));
  end

  data_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW)
  ) u_ram (
    .clk   (clk),
    .we    (we_p0),
    .waddr (waddr_p0),
    .wdata (bus.data_in),
    .raddr (raddr_p0),
    .rdata (rdata_p0)
  );

  // Stage p1: SP register and MEM/WB register
  always_ff @(posedge clk) begin
    if (!rst) begin
      sp_p1        <= SP_INIT;
      vld_p1       <= 1'b0;
      wb_data_p1   <= '0;
      wb_rd_p1     <= '0;
      wb_reg_we_p1 <= 1'b0;
      stack_err_p1 <= 1'b0;
    end else if (!bus.stall) begin
      sp_p1        <= sp_nxt_p0;
      vld_p1       <= vld_p0;
      wb_data_p1   <= wb_data_nxt_p0;
      wb_rd_p1     <= bus.rd;
      wb_reg_we_p1 <= reg_we_nxt_p0;
      if (stack_fault_p0) begin
        stack_err_p1 <= 1'b1;
      end
    end
  end

  assign bus.wb_valid  = vld_p1;
  assign bus.wb_data   = wb_data_p1;
  assign bus.wb_rd     = wb_rd_p1;
  assign bus.wb_reg_we = wb_reg_we_p1;
  assign bus.sp_out    = sp_p1;
  assign bus.stack_err = stack_err_p1;

endmodule

// File: tb/tb_mem_stack_stage.sv
module tb_mem_stack_stage;
  import mem_stage_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_stack_stage_if #(.AW(8), .DW(8)) bus();

  mem_stack_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural reference: a byte array, a stack pointer and the wb outputs.
  logic [7:0] m_mem [256];
  logic [7:0] m_sp;
  logic [7:0] m_wbd;
  logic [1:0] m_wbrd;
  logic       m_wbv;
  logic       m_wbwe;
  logic       m_err;
  bit         m_known = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    int e;
    logic [7:0] d;
    if (!rst) begin
      m_sp = 8'hFF; m_wbv = 0; m_wbd = 0; m_wbrd = 0; m_wbwe = 0; m_err = 0;
      m_known = 1;
    end else if (!bus.stall) begin
      e = (bus.valid && !bus.flush && bus.op <= 3'd4) ? int'(bus.op) : 0;
      d = bus.alu_result;
      case (e)
        1: d = m_mem[bus.addr];
        2: m_mem[bus.addr] = bus.data_in;
        3: begin
          m_mem[m_sp] = bus.data_in;
          if (m_sp == 8'h00) m_err = 1;
          m_sp = m_sp - 8'd1;
        end
        4: begin
          if (m_sp == 8'hFF) m_err = 1;
          m_sp = m_sp + 8'd1;
          d = m_mem[m_sp];
        end
        default: ;
      endcase
      m_wbv  = bus.valid && !bus.flush;
      m_wbd  = d;
      m_wbrd = bus.rd;
      m_wbwe = bus.reg_we_in && m_wbv && !(e == 2 || e == 3);
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      chk("sp_out",    32'(bus.sp_out),    32'(m_sp));
      chk("wb_valid",  32'(bus.wb_valid),  32'(m_wbv));
      chk("wb_data",   32'(bus.wb_data),   32'(m_wbd));
      chk("wb_rd",     32'(bus.wb_rd),     32'(m_wbrd));
      chk("wb_reg_we", 32'(bus.wb_reg_we), 32'(m_wbwe));
      chk("stack_err", 32'(bus.stack_err), 32'(m_err));
    end
  end

  task automatic drive(input bit v, input logic [2:0] o, input logic [7:0] a,
                       input logic [7:0] d, input logic [7:0] alu, input logic [1:0] r,
                       input bit we, input bit st, input bit fl);
    bus.valid = v; bus.op = o; bus.addr = a; bus.data_in = d;
    bus.alu_result = alu; bus.rd = r; bus.reg_we_in = we;
    bus.stall = st; bus.flush = fl;
    @(negedge clk);
  endtask

  task automatic idle();
    drive(0, OP_NONE, 8'h00, 8'h00, 8'h00, 2'd0, 0, 0, 0);
  endtask

  initial begin
    // 1. reset
    rst = 0;
    idle(); idle();
    chk("rst_sp", 32'(bus.sp_out), 32'h0FF);
    chk("rst_wbv", 32'(bus.wb_valid), 32'h0);
    chk("rst_wbwe", 32'(bus.wb_reg_we), 32'h0);
    chk("rst_err", 32'(bus.stack_err), 32'h0);
    rst = 1;

    // fill RAM so every later read has a known value
    for (int i = 0; i < 256; i++)
      drive(1, OP_STORE, 8'(i), 8'($urandom), 8'($urandom), 2'($urandom), 1, 0, 0);

    // 2. store then load same address
    drive(1, OP_STORE, 8'h10, 8'hA5, 8'h11, 2'd1, 1, 0, 0);
    chk("store_wbwe", 32'(bus.wb_reg_we), 32'h0);
    chk("store_wbd", 32'(bus.wb_data), 32'h11);
    drive(1, OP_LOAD, 8'h10, 8'h00, 8'h22, 2'd2, 1, 0, 0);
    chk("load_wbd", 32'(bus.wb_data), 32'hA5);
    chk("load_rd", 32'(bus.wb_rd), 32'h2);
    chk("load_wbwe", 32'(bus.wb_reg_we), 32'h1);

    // 3. push, push, pop, pop
    drive(1, OP_PUSH, 8'h00, 8'h3C, 8'h00, 2'd0, 1, 0, 0);
    chk("push1_sp", 32'(bus.sp_out), 32'h0FE);
    drive(1, OP_PUSH, 8'h00, 8'h7E, 8'h00, 2'd0, 1, 0, 0);
    chk("push2_sp", 32'(bus.sp_out), 32'h0FD);
    drive(1, OP_POP, 8'h00, 8'h00, 8'h00, 2'd3, 1, 0, 0);
    chk("pop1_wbd", 32'(bus.wb_data), 32'h7E);
    chk("pop1_sp", 32'(bus.sp_out), 32'h0FE);
    drive(1, OP_POP, 8'h00, 8'h00, 8'h00, 2'd3, 1, 0, 0);
    chk("pop2_wbd", 32'(bus.wb_data), 32'h3C);
    chk("pop2_sp", 32'(bus.sp_out), 32'h0FF);

    // 4. underflow then overflow
    drive(1, OP_POP, 8'h00, 8'h00, 8'h00, 2'd0, 1, 0, 0);
    chk("unf_sp", 32'(bus.sp_out), 32'h000);
    chk("unf_err", 32'(bus.stack_err), 32'h1);
    drive(1, OP_PUSH, 8'h00, 8'h5A, 8'h00, 2'd0, 1, 0, 0);
    chk("ovf_sp", 32'(bus.sp_out), 32'h0FF);
    chk("ovf_err", 32'(bus.stack_err), 32'h1);
    drive(1, OP_LOAD, 8'h00, 8'h00, 8'h00, 2'd1, 1, 0, 0);
    chk("ovf_mem0", 32'(bus.wb_data), 32'h5A);

    // 5. stalled push, flush ignored while stalled
    for (int i = 0; i < 3; i++) begin
      drive(1, OP_PUSH, 8'h00, 8'h99, 8'h00, 2'd0, 0, 1, (i == 1));
      chk("stall_sp", 32'(bus.sp_out), 32'h0FF);
      chk("stall_wbd", 32'(bus.wb_data), 32'h5A);
    end
    drive(1, OP_PUSH, 8'h00, 8'h99, 8'h00, 2'd0, 0, 0, 0);
    chk("unstall_sp", 32'(bus.sp_out), 32'h0FE);
    drive(1, OP_LOAD, 8'hFF, 8'h00, 8'h00, 2'd0, 1, 0, 0);
    chk("unstall_mem", 32'(bus.wb_data), 32'h99);

    // 6. flushed load, then reset mid-sequence at SP=FB
    drive(1, OP_STORE, 8'hFE, 8'h00, 8'h00, 2'd0, 0, 0, 1);
    drive(1, OP_LOAD, 8'hFF, 8'h00, 8'h44, 2'd1, 1, 0, 1);
    chk("flush_wbv", 32'(bus.wb_valid), 32'h0);
    chk("flush_wbwe", 32'(bus.wb_reg_we), 32'h0);
    chk("flush_sp", 32'(bus.sp_out), 32'h0FE);
    for (int i = 0; i < 3; i++)
      drive(1, OP_PUSH, 8'h00, 8'(i), 8'h00, 2'd0, 0, 0, 0);
    chk("pre_rst_sp", 32'(bus.sp_out), 32'h0FB);
    rst = 0;
    drive(1, OP_PUSH, 8'h00, 8'hEE, 8'h00, 2'd0, 1, 0, 0);
    chk("mid_rst_sp", 32'(bus.sp_out), 32'h0FF);
    chk("mid_rst_err", 32'(bus.stack_err), 32'h0);
    rst = 1;

    // randomized traffic, checked every cycle against the model
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) != 0);
      drive($urandom_range(0, 9) != 0, 3'($urandom_range(0, 7)), 8'($urandom),
            8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom),
            $urandom_range(0, 4) == 0, $urandom_range(0, 6) == 0);
    end
    rst = 1;
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stack_stage.md
Name: mem_stack_stage

Overview:
Memory-access stage of the 8-bit pipelined core, directly downstream of the data-memory write-data mux; consumes its Data_In byte.
- Holds the 256x8 data RAM and the stack pointer (SP).
- Performs LOAD/STORE/PUSH/POP, one operation per cycle.
- Registers the MEM/WB pipeline outputs feeding register-file writeback.

Parameters:
DEPTH, 256, number of RAM bytes; must equal 2^AW.
AW, 8, address/SP width.
DW, 8, data width.
SP_INIT, 8'hFF, SP value after reset.

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-low (asserted when 0)
valid  in  1  op/operands from EX/MEM are meaningful this cycle
op  in  3  memory operation code (see package)
addr  in  AW  effective address for LOAD/STORE
data_in  in  DW  write byte from the data-memory mux (rb / next PC / PC)
alu_result  in  DW  pass-through result for non-load writeback
rd  in  2  destination register index
reg_we_in  in  1  register write enable from decode
stall  in  1  hold stage
flush  in  1  squash current op
wb_valid  out  1  MEM/WB entry valid
wb_data  out  DW  writeback value
wb_rd  out  2  writeback register index
wb_reg_we  out  1  writeback enable
sp_out  out  AW  current SP (for debug / SP-relative ops upstream)
stack_err  out  1  sticky overflow/underflow flag

Behaviour:
- Reset (rst==0 at clk edge): SP<=SP_INIT; wb_valid, wb_data, wb_rd, wb_reg_we <= 0; stack_err<=0. RAM contents not reset.
- Effective op: NONE if valid==0 or flush==1; codes 5-7 decode as NONE.
- Priority: reset > stall > flush > op.
- Stall==1:
  - No RAM write, no SP change.
  - All wb_* and stack_err hold.
  - flush ignored that cycle.
- RAM: combinational read, synchronous write at clk edge.
  - A STORE followed next cycle by a LOAD to the same address returns the new byte.
- LOAD: read mem[addr]; wb_data<=mem[addr].
- STORE: mem[addr]<=data_in; wb_reg_we<=0.
- PUSH:
  - mem[SP]<=data_in; SP<=SP-1 (mod 256); wb_reg_we<=0.
  - If SP==8'h00 before push: write still occurs, SP wraps to 8'hFF, stack_err<=1.
- POP:
  - Read mem[SP+1] (mod 256); SP<=SP+1; wb_data<=read byte.
  - If SP==8'hFF before pop: reads mem[0], SP wraps to 8'h00, stack_err<=1.
- NONE: no RAM write, no SP change.
- wb_data for NONE/STORE/PUSH = alu_result.
- Non-stalled cycle register update (latency: 1 cycle, input to wb_*):
  - wb_valid<=effective op valid (valid & ~flush).
  - wb_rd<=rd.
  - wb_reg_we<=reg_we_in & valid & ~flush & ~(STORE|PUSH).
- stack_err is sticky; clears only on reset.
- sp_out = SP register, no extra delay.

Decomposition:
- Package mem_stage_pkg:
  - OP_NONE=3'd0, OP_LOAD=3'd1, OP_STORE=3'd2, OP_PUSH=3'd3, OP_POP=3'd4.
  - SP_INIT default constant.
- One sub-module data_ram: DEPTH x DW, one async-read port, one sync-write port (we, waddr, wdata, raddr, rdata).
- Address mux, SP logic and MEM/WB register stay in mem_stack_stage.

Test Plan:
1. Reset: hold rst=0 two cycles, release -> sp_out=8'hFF, wb_valid=0, wb_reg_we=0, stack_err=0.
2. STORE addr=8'h10 data_in=8'hA5, next cycle LOAD addr=8'h10 rd=2 reg_we_in=1 -> one cycle later wb_data=8'hA5, wb_rd=2, wb_reg_we=1; STORE's wb_reg_we=0.
3. PUSH data_in=8'h3C, then PUSH data_in=8'h7E:
   - sp_out 8'hFF->8'hFE->8'hFD; mem[FF]=3C, mem[FE]=7E.
   - POP, POP -> wb_data 8'h7E then 8'h3C; sp_out back to 8'hFF.
4. Boundary: POP at SP=8'hFF -> sp_out=8'h00, stack_err=1 and stays 1.
   - Fill to SP=8'h00 via pushes, PUSH once more -> mem[0] written, sp_out=8'hFF, stack_err still 1.
5. Stall: PUSH with stall=1 for 3 cycles, then stall=0:
   - SP and wb_* frozen during stall; single write and single SP decrement after release.
   - flush=1 with stall=1 has no effect.
6. Flush: LOAD with flush=1, stall=0 -> wb_valid=0, wb_reg_we=0, SP unchanged, RAM unchanged. Then rst=0 mid-sequence with SP=8'hFB -> sp_out=8'hFF next cycle.
